// File: rtl/stage_fetch0_bp_pkg.sv
// Shared types for the fetch0 stage and its branch target buffer.
// Holds the BTB entry layout, counter encodings and the counter update rule.
package stage_fetch0_bp_pkg;

    // 2-bit saturating direction counter encodings
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Tag is kept at full word-address width; unused upper bits stay zero
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_ctr(
        input logic [1:0] c,
        input logic       taken
    );
        if (taken) begin
            return (c == ST) ? ST : c + 2'd1;
        end
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/stage_fetch0_bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup, one update
// port applied at the next edge, and a flush that clears every valid bit.
// Ports: clk_core, reset_n, flush, lk_addr -> lk_taken/lk_target,
//        wr_en/wr_pc/wr_target/wr_taken update.
module fetch_btb
    import stage_fetch0_bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk_core,
    input  logic        reset_n,
    input  logic        flush,
    input  logic [29:0] lk_addr,
    output logic        lk_taken,
    output logic [29:0] lk_target,
    input  logic        wr_en,
    input  logic [29:0] wr_pc,
    input  logic [29:0] wr_target,
    input  logic        wr_taken
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    btb_entry_t btb_q [ENTRIES];
    btb_entry_t btb_d [ENTRIES];

    logic [IDX-1:0] lk_idx;
    logic [29:0]    lk_tag;
    btb_entry_t     lk_ent;
    logic [IDX-1:0] wr_idx;
    logic [29:0]    wr_tag;
    btb_entry_t     wr_ent;
    logic           wr_hit;

    always_comb begin
        lk_idx    = lk_addr[IDX-1:0];
        lk_tag    = {{IDX{1'b0}}, lk_addr[29:IDX]};
        lk_ent    = btb_q[lk_idx];
        // Upper counter bit set means WT or ST
        lk_taken  = lk_ent.valid && (lk_ent.tag == lk_tag) && lk_ent.ctr[1];
        lk_target = lk_ent.target;
    end

    always_comb begin
        btb_d  = btb_q;
        wr_idx = wr_pc[IDX-1:0];
        wr_tag = {{IDX{1'b0}}, wr_pc[29:IDX]};
        wr_ent = btb_q[wr_idx];
        wr_hit = wr_ent.valid && (wr_ent.tag == wr_tag);
        if (flush) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btb_d[i].valid = 1'b0;
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                btb_d[wr_idx].ctr = sat_ctr(wr_ent.ctr, wr_taken);
                if (wr_taken) begin
                    btb_d[wr_idx].target = wr_target;
                end
            end else if (wr_taken) begin
                // Not-taken misses are not worth an entry
                btb_d[wr_idx].valid  = 1'b1;
                btb_d[wr_idx].tag    = wr_tag;
                btb_d[wr_idx].target = wr_target;
                btb_d[wr_idx].ctr    = WT;
            end
        end
    end

    // Only valid bits are reset; payload fields are don't-care until allocated
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btb_q[i].valid <= 1'b0;
            end
        end else begin
            btb_q <= btb_d;
        end
    end

endmodule

// File: rtl/stage_fetch0_bp.sv
// Fetch stage 0: next-PC selection, icache request and BTB prediction.
// Ports: clk_core/reset_n, fe1_stall, decode redirect and BTB update,
//        CSR redirect/kill/flush/satp, icache request and prediction out.
module stage_fetch0_bp
    import stage_fetch0_bp_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk_core,
    input  logic        reset_n,
    output logic        fe0_valid,
    input  logic        fe1_stall,
    output logic        fe0_read_req,
    output logic [8:0]  fe0_read_asid,
    output logic [29:0] fe0_read_addr,
    output logic        fe0_pred_taken,
    output logic [29:0] fe0_pred_target,
    input  logic        de_setpc,
    input  logic [29:0] de_newpc,
    input  logic        de_btb_wr,
    input  logic [29:0] de_btb_pc,
    input  logic [29:0] de_btb_target,
    input  logic        de_btb_taken,
    input  logic        csr_kill,
    input  logic        csr_setpc,
    input  logic [29:0] csr_newpc,
    input  logic        csr_btb_flush,
    input  logic [31:0] csr_satp
);

    logic [29:0] fe0_pc_q;
    logic [29:0] fe0_pc_d;
    logic        btb_taken;
    logic [29:0] btb_target;
    logic        unused_satp;

    assign unused_satp = ^{csr_satp[31], csr_satp[21:0]};

    always_comb begin
        // A CSR redirect forces a fetch even into a stalled fetch1
        fe0_read_req = (~fe1_stall | csr_setpc) & ~csr_kill;
        fe0_valid    = fe0_read_req;
        fe0_read_asid = csr_satp[30:22];
        if (csr_setpc) begin
            fe0_read_addr = csr_newpc;
        end else if (de_setpc) begin
            fe0_read_addr = de_newpc;
        end else begin
            fe0_read_addr = fe0_pc_q;
        end
        fe0_pred_taken  = btb_taken;
        fe0_pred_target = btb_taken ? btb_target : 30'd0;
    end

    // Kill already folds into read_req, so it alone gates the PC update
    always_comb begin
        fe0_pc_d = fe0_pc_q;
        if (fe0_read_req) begin
            if (fe0_pred_taken) begin
                fe0_pc_d = fe0_pred_target;
            end else begin
                fe0_pc_d = fe0_read_addr + 30'd1;
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            fe0_pc_q <= RESET_PC[31:2];
        end else begin
            fe0_pc_q <= fe0_pc_d;
        end
    end

    fetch_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk_core  (clk_core),
        .reset_n   (reset_n),
        .flush     (csr_btb_flush),
        .lk_addr   (fe0_read_addr),
        .lk_taken  (btb_taken),
        .lk_target (btb_target),
        .wr_en     (de_btb_wr),
        .wr_pc     (de_btb_pc),
        .wr_target (de_btb_target),
        .wr_taken  (de_btb_taken)
    );

endmodule

// File: tb/tb_stage_fetch0_bp.sv
// Directed bench for stage_fetch0_bp with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled before the next rise.
module tb_stage_fetch0_bp;

    logic        clk_core = 1'b0;
    logic        reset_n;
    logic        fe0_valid;
    logic        fe1_stall;
    logic        fe0_read_req;
    logic [8:0]  fe0_read_asid;
    logic [29:0] fe0_read_addr;
    logic        fe0_pred_taken;
    logic [29:0] fe0_pred_target;
    logic        de_setpc;
    logic [29:0] de_newpc;
    logic        de_btb_wr;
    logic [29:0] de_btb_pc;
    logic [29:0] de_btb_target;
    logic        de_btb_taken;
    logic        csr_kill;
    logic        csr_setpc;
    logic [29:0] csr_newpc;
    logic        csr_btb_flush;
    logic [31:0] csr_satp;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_core = ~clk_core;

    stage_fetch0_bp #(
        .BTB_ENTRIES (16),
        .RESET_PC    (32'h100)
    ) dut (
        .clk_core        (clk_core),
        .reset_n         (reset_n),
        .fe0_valid       (fe0_valid),
        .fe1_stall       (fe1_stall),
        .fe0_read_req    (fe0_read_req),
        .fe0_read_asid   (fe0_read_asid),
        .fe0_read_addr   (fe0_read_addr),
        .fe0_pred_taken  (fe0_pred_taken),
        .fe0_pred_target (fe0_pred_target),
        .de_setpc        (de_setpc),
        .de_newpc        (de_newpc),
        .de_btb_wr       (de_btb_wr),
        .de_btb_pc       (de_btb_pc),
        .de_btb_target   (de_btb_target),
        .de_btb_taken    (de_btb_taken),
        .csr_kill        (csr_kill),
        .csr_setpc       (csr_setpc),
        .csr_newpc       (csr_newpc),
        .csr_btb_flush   (csr_btb_flush),
        .csr_satp        (csr_satp)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        @(negedge clk_core);
    endtask

    task automatic btb_upd(input logic [29:0] pc, input logic [29:0] tgt,
                           input logic taken);
        de_btb_wr     = 1'b1;
        de_btb_pc     = pc;
        de_btb_target = tgt;
        de_btb_taken  = taken;
        step();
        de_btb_wr     = 1'b0;
    endtask

    // Combinational lookup through a decode redirect, no clock edge
    task automatic probe(input string tag, input logic [29:0] a,
                         input logic exp_t, input logic [29:0] exp_tgt);
        de_setpc = 1'b1;
        de_newpc = a;
        #1;
        check_eq({tag, "_addr"}, {2'b0, fe0_read_addr}, {2'b0, a});
        check_eq({tag, "_pt"}, {31'b0, fe0_pred_taken}, {31'b0, exp_t});
        check_eq({tag, "_tgt"}, {2'b0, fe0_pred_target}, {2'b0, exp_tgt});
        de_setpc = 1'b0;
        #1;
    endtask

    task automatic seq_chk(input string tag, input logic [29:0] a);
        check_eq({tag, "_addr"}, {2'b0, fe0_read_addr}, {2'b0, a});
        check_eq({tag, "_pt"}, {31'b0, fe0_pred_taken}, 32'd0);
        check_eq({tag, "_req"}, {31'b0, fe0_read_req}, 32'd1);
        check_eq({tag, "_vld"}, {31'b0, fe0_valid}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        fe1_stall = 1'b0;
        de_setpc = 1'b0;
        de_newpc = '0;
        de_btb_wr = 1'b0;
        de_btb_pc = '0;
        de_btb_target = '0;
        de_btb_taken = 1'b0;
        csr_kill = 1'b0;
        csr_setpc = 1'b0;
        csr_newpc = '0;
        csr_btb_flush = 1'b0;
        csr_satp = 32'h1234_5678;

        step();
        step();
        reset_n = 1'b1;
        #1;
        check_eq("asid", {23'b0, fe0_read_asid}, 32'h48);
        seq_chk("rst0", 30'h40);
        step();
        seq_chk("rst1", 30'h41);
        step();
        seq_chk("rst2", 30'h42);

        // Allocate 0x41 -> 0x80 while looking it up in the same cycle
        de_btb_wr = 1'b1;
        de_btb_pc = 30'h41;
        de_btb_target = 30'h80;
        de_btb_taken = 1'b1;
        de_setpc = 1'b1;
        de_newpc = 30'h41;
        #1;
        check_eq("same_cyc_pt", {31'b0, fe0_pred_taken}, 32'd0);
        check_eq("same_cyc_tgt", {2'b0, fe0_pred_target}, 32'd0);
        step();
        de_btb_wr = 1'b0;
        #1;
        check_eq("hit_pt", {31'b0, fe0_pred_taken}, 32'd1);
        check_eq("hit_tgt", {2'b0, fe0_pred_target}, 32'h80);
        step();
        de_setpc = 1'b0;
        #1;
        seq_chk("follow", 30'h80);

        // Counter walk: 2 -> 1 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2 -> 1
        btb_upd(30'h41, 30'h80, 1'b0);
        probe("c1", 30'h41, 1'b0, 30'h0);
        btb_upd(30'h41, 30'h80, 1'b0);
        probe("c0", 30'h41, 1'b0, 30'h0);
        btb_upd(30'h41, 30'h80, 1'b1);
        probe("c1b", 30'h41, 1'b0, 30'h0);
        btb_upd(30'h41, 30'h80, 1'b1);
        probe("c2", 30'h41, 1'b1, 30'h80);
        btb_upd(30'h41, 30'h80, 1'b1);
        btb_upd(30'h41, 30'h80, 1'b1);
        btb_upd(30'h41, 30'h80, 1'b0);
        probe("sat_c2", 30'h41, 1'b1, 30'h80);
        btb_upd(30'h41, 30'h80, 1'b0);
        probe("sat_c1", 30'h41, 1'b0, 30'h0);
        btb_upd(30'h41, 30'h90, 1'b1);
        probe("retgt", 30'h41, 1'b1, 30'h90);

        // Flush beats a simultaneous allocate
        csr_btb_flush = 1'b1;
        btb_upd(30'h22, 30'h33, 1'b1);
        csr_btb_flush = 1'b0;
        probe("fl41", 30'h41, 1'b0, 30'h0);
        probe("fl22", 30'h22, 1'b0, 30'h0);

        // Alias on the same index misses; a not-taken miss leaves it alone
        btb_upd(30'h41, 30'h80, 1'b1);
        probe("al41", 30'h41, 1'b1, 30'h80);
        probe("al51", 30'h51, 1'b0, 30'h0);
        btb_upd(30'h51, 30'h99, 1'b0);
        probe("keep41", 30'h41, 1'b1, 30'h80);
        probe("miss51", 30'h51, 1'b0, 30'h0);

        // CSR redirect wins over decode and a stall
        fe1_stall = 1'b1;
        csr_setpc = 1'b1;
        csr_newpc = 30'h200;
        de_setpc = 1'b1;
        de_newpc = 30'h300;
        #1;
        check_eq("csr_addr", {2'b0, fe0_read_addr}, 32'h200);
        check_eq("csr_req", {31'b0, fe0_read_req}, 32'd1);
        step();
        csr_setpc = 1'b0;
        de_setpc = 1'b0;
        #1;
        check_eq("csr_next", {2'b0, fe0_read_addr}, 32'h201);
        check_eq("stall_req", {31'b0, fe0_read_req}, 32'd0);

        // Kill blocks the request and holds the PC
        fe1_stall = 1'b0;
        csr_kill = 1'b1;
        csr_setpc = 1'b1;
        csr_newpc = 30'h500;
        #1;
        check_eq("kill_req", {31'b0, fe0_read_req}, 32'd0);
        check_eq("kill_vld", {31'b0, fe0_valid}, 32'd0);
        step();
        csr_kill = 1'b0;
        csr_setpc = 1'b0;
        fe1_stall = 1'b1;
        #1;
        check_eq("kill_hold", {2'b0, fe0_read_addr}, 32'h201);

        // Decode redirect during a stall is dropped
        de_setpc = 1'b1;
        de_newpc = 30'h700;
        #1;
        check_eq("de_stall_req", {31'b0, fe0_read_req}, 32'd0);
        step();
        de_setpc = 1'b0;
        #1;
        check_eq("de_drop", {2'b0, fe0_read_addr}, 32'h201);
        step();
        check_eq("stall_stable", {2'b0, fe0_read_addr}, 32'h201);

        // Wrap at top of the address space
        fe1_stall = 1'b0;
        csr_setpc = 1'b1;
        csr_newpc = 30'h3FFF_FFFF;
        step();
        csr_setpc = 1'b0;
        #1;
        seq_chk("wrap", 30'h0);

        // Mid-stream reset drops a pending taken prediction
        de_setpc = 1'b1;
        de_newpc = 30'h41;
        #1;
        check_eq("pre_rst_pt", {31'b0, fe0_pred_taken}, 32'd1);
        reset_n = 1'b0;
        step();
        de_setpc = 1'b0;
        reset_n = 1'b1;
        #1;
        seq_chk("mrst0", 30'h40);
        step();
        seq_chk("mrst1", 30'h41);
        step();
        seq_chk("mrst2", 30'h42);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
